cbp_dec: RTL

Bit-serial inverse of the CAVLC coded_block_pattern mapping. It parses one ue(v) Exp-Golomb codeword from a 1-bit/cycle stream, giving codeNum 0..47. It then maps codeNum back to the 6-bit CBP using the Intra4x4 or Inter table (H.264 Table 9-4). It sits in the decode-side / bitstream-checker path, between the bit-reader and the macroblock-header parser.

---
 rtl/cbp_dec_pkg.sv | 15 +
 rtl/cbp_dec_map.sv | 35 +++
 rtl/cbp_dec.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cbp_dec_pkg.sv
// Shared definitions for the CAVLC coded_block_pattern decoder.
package cbp_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_SUFFIX = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  localparam int   CBP_MAX_CODE  = 47;
  localparam logic MODE_INTRA4X4 = 1'b0;
  localparam logic MODE_INTER    = 1'b1;

endpackage

// File: rtl/cbp_dec_map.sv
// Combinational codeNum -> CBP inverse mapping (H.264 Table 9-4), both prediction modes.
module cbp_dec_map
  import cbp_dec_pkg::*;
(
  input  logic [5:0] code,
  input  logic       mode,
  output logic [5:0] cbp
);

  localparam logic [5:0] INTRA_TBL [0:47] = '{
    6'd47, 6'd31, 6'd15, 6'd0,  6'd23, 6'd27, 6'd29, 6'd30,
    6'd7,  6'd11, 6'd13, 6'd14, 6'd39, 6'd43, 6'd45, 6'd46,
    6'd16, 6'd3,  6'd5,  6'd10, 6'd12, 6'd19, 6'd21, 6'd26,
    6'd28, 6'd35, 6'd37, 6'd42, 6'd44, 6'd1,  6'd2,  6'd4,
    6'd8,  6'd17, 6'd18, 6'd20, 6'd24, 6'd6,  6'd9,  6'd22,
    6'd25, 6'd32, 6'd33, 6'd34, 6'd36, 6'd40, 6'd38, 6'd41
  };

  localparam logic [5:0] INTER_TBL [0:47] = '{
    6'd0,  6'd16, 6'd1,  6'd2,  6'd4,  6'd8,  6'd32, 6'd3,
    6'd5,  6'd10, 6'd12, 6'd15, 6'd47, 6'd7,  6'd11, 6'd13,
    6'd14, 6'd6,  6'd9,  6'd31, 6'd35, 6'd37, 6'd42, 6'd44,
    6'd33, 6'd34, 6'd36, 6'd40, 6'd39, 6'd43, 6'd45, 6'd46,
    6'd17, 6'd18, 6'd20, 6'd24, 6'd19, 6'd21, 6'd26, 6'd28,
    6'd23, 6'd27, 6'd29, 6'd30, 6'd22, 6'd25, 6'd38, 6'd41
  };

  always_comb begin
    cbp = '0;
    if (code <= 6'(CBP_MAX_CODE)) begin
      cbp = (mode == MODE_INTER) ? INTER_TBL[code] : INTRA_TBL[code];
    end
  end

endmodule

// File: rtl/cbp_dec.sv
// Bit-serial ue(v) parser that recovers the 6-bit coded_block_pattern from one codeword.
// One bit per cycle in PREFIX/SUFFIX; result held in OUT until cbp_ready_i.
module cbp_dec
  import cbp_dec_pkg::*;
#(
  parameter int MAX_LZ = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  output logic [5:0] cbp_o,
  output logic [3:0] len_o,
  output logic       err_o,
  output logic       cbp_valid_o,
  input  logic       cbp_ready_i,
  output logic       busy_o
);

  localparam int LZW = $clog2(MAX_LZ + 2);

  state_t           state, state_nx;
  logic             mode_q;
  logic [LZW-1:0]   lz_cnt;
  logic [LZW-1:0]   sfx_cnt;
  logic [MAX_LZ-1:0] info;
  logic [MAX_LZ-1:0] info_nx;
  logic [6:0]       code_sum;
  logic [5:0]       map_code;
  logic [5:0]       map_cbp;
  logic             bit_acc;
  logic             last_sfx;

  assign bit_acc  = bit_valid_i & bit_ready_o;
  assign last_sfx = (sfx_cnt == LZW'(1));
  assign info_nx  = {info[MAX_LZ-2:0], bit_i};
  // info_nx holds exactly lz suffix bits on the last suffix cycle since info starts cleared
  assign code_sum = ((7'd1 << lz_cnt) - 7'd1) + 7'(info_nx);
  assign map_code = (state == ST_SUFFIX) ? code_sum[5:0] : 6'd0;

  cbp_dec_map u_map (
    .code (map_code),
    .mode (mode_q),
    .cbp  (map_cbp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_i) state_nx = ST_PREFIX;
      ST_PREFIX: begin
        if (bit_valid_i) begin
          if (!bit_i) begin
            if (lz_cnt == LZW'(MAX_LZ)) state_nx = ST_OUT;
          end else begin
            state_nx = (lz_cnt == '0) ? ST_OUT : ST_SUFFIX;
          end
        end
      end
      ST_SUFFIX: if (bit_valid_i && last_sfx) state_nx = ST_OUT;
      ST_OUT:    if (cbp_ready_i) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_ready_o = (state == ST_PREFIX) || (state == ST_SUFFIX);
    cbp_valid_o = (state == ST_OUT);
    busy_o      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= 1'b0;
      lz_cnt  <= '0;
      sfx_cnt <= '0;
      info    <= '0;
      cbp_o   <= '0;
      len_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            lz_cnt <= '0;
            info   <= '0;
          end
        end
        ST_PREFIX: begin
          if (bit_acc) begin
            if (!bit_i) begin
              if (lz_cnt == LZW'(MAX_LZ)) begin
                err_o <= 1'b1;
                cbp_o <= '0;
                len_o <= 4'(MAX_LZ + 1);
              end else begin
                lz_cnt <= lz_cnt + LZW'(1);
              end
            end else if (lz_cnt == '0) begin
              err_o <= 1'b0;
              cbp_o <= map_cbp;
              len_o <= 4'd1;
            end else begin
              sfx_cnt <= lz_cnt;
            end
          end
        end
        ST_SUFFIX: begin
          if (bit_acc) begin
            info    <= info_nx;
            sfx_cnt <= sfx_cnt - LZW'(1);
            if (last_sfx) begin
              len_o <= 4'({lz_cnt, 1'b1});
              if (code_sum > 7'(CBP_MAX_CODE)) begin
                err_o <= 1'b1;
                cbp_o <= '0;
              end else begin
                err_o <= 1'b0;
                cbp_o <= map_cbp;
              end
            end
          end
        end
        ST_OUT: begin
          if (cbp_ready_i) err_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
